// File: rtl/hpram_arbiter.sv
// Round-robin burst arbiter sharing the HyperRAM command port between the
// frame-buffer write (ingress) and read (egress) channels, dma_clk domain.
module hpram_arbiter #(
    parameter int BURST_WORDS = 16,
    parameter int CMD_GAP     = 4,
    parameter int RD_TIMEOUT  = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        init_calib,
    input  logic        wr_req,
    input  logic [21:0] wr_addr,
    output logic        wr_grant,
    output logic        wr_rden,
    input  logic [31:0] wr_data_in,
    output logic        wr_done,
    input  logic        rd_req,
    input  logic [21:0] rd_addr,
    output logic        rd_grant,
    output logic [31:0] rd_data_out,
    output logic        rd_wren,
    output logic        rd_done,
    output logic        rd_timeout_err,
    output logic        cmd,
    output logic        cmd_en,
    output logic [21:0] addr,
    output logic [31:0] wr_data,
    output logic [3:0]  data_mask,
    input  logic        rd_data_valid,
    input  logic [31:0] rd_data
);

    localparam int CW = $clog2(BURST_WORDS) + 1;
    localparam int TW = $clog2(RD_TIMEOUT) + 1;
    localparam int GW = $clog2(CMD_GAP) + 1;

    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_WORDS - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(BURST_WORDS - 2);
    localparam logic [TW-1:0] TO_LAST   = TW'(RD_TIMEOUT - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(CMD_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, WR_PREF, WR_BURST, RD_WAIT, GAP
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [21:0] addr_q, addr_d;
    logic        cmd_q, cmd_d;
    logic        cmd_en_q, cmd_en_d;
    logic        last_rd_q, last_rd_d;
    logic        err_q, err_d;
    logic        wr_grant_q, wr_grant_d;
    logic        rd_grant_q, rd_grant_d;
    logic        wr_rden_q, wr_rden_d;
    logic        wr_done_q, wr_done_d;
    logic        to_done_q, to_done_d;

    logic rd_active, rd_last, arb_ok, pick_rd, pick_wr;

    // The grant cycle itself sits in RD_WAIT; data is only accepted after cmd_en.
    assign rd_active = (state_q == RD_WAIT) && !rd_grant_q && init_calib;
    assign rd_last   = rd_active && rd_data_valid && (cnt_q == LAST_BEAT);

    assign arb_ok  = init_calib &&
                     ((state_q == IDLE) ||
                      ((state_q == GAP) && (gap_q == GAP_LAST)));
    assign pick_rd = arb_ok && rd_req && (!wr_req || !last_rd_q);
    assign pick_wr = arb_ok && wr_req && !pick_rd;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        timer_d    = timer_q;
        gap_d      = gap_q;
        addr_d     = addr_q;
        cmd_d      = cmd_q;
        last_rd_d  = last_rd_q;
        err_d      = err_q;
        cmd_en_d   = 1'b0;
        wr_grant_d = 1'b0;
        rd_grant_d = 1'b0;
        wr_rden_d  = 1'b0;
        wr_done_d  = 1'b0;
        to_done_d  = 1'b0;

        unique case (state_q)
            IDLE: ;
            WR_PREF: begin
                state_d   = WR_BURST;
                cmd_en_d  = 1'b1;
                wr_rden_d = 1'b1;
                cnt_d     = '0;
            end
            WR_BURST: begin
                cnt_d     = cnt_q + 1'b1;
                wr_rden_d = (cnt_q < PRE_LAST);
                wr_done_d = (cnt_q == PRE_LAST);
                if (cnt_q == LAST_BEAT) begin
                    state_d = GAP;
                    gap_d   = '0;
                end
            end
            RD_WAIT: begin
                if (rd_grant_q) begin
                    cmd_en_d = 1'b1;
                    timer_d  = '0;
                    cnt_d    = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                    if (rd_active && rd_data_valid)
                        cnt_d = cnt_q + 1'b1;
                    if (rd_last) begin
                        state_d = GAP;
                        gap_d   = '0;
                    end else if (timer_q == TO_LAST) begin
                        err_d     = 1'b1;
                        to_done_d = 1'b1;
                        state_d   = GAP;
                        gap_d     = '0;
                    end
                end
            end
            GAP: begin
                gap_d = gap_q + 1'b1;
                if (gap_q == GAP_LAST)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (pick_rd) begin
            state_d    = RD_WAIT;
            rd_grant_d = 1'b1;
            addr_d     = rd_addr;
            cmd_d      = 1'b1;
            last_rd_d  = 1'b1;
        end else if (pick_wr) begin
            state_d    = WR_PREF;
            wr_grant_d = 1'b1;
            wr_rden_d  = 1'b1;
            addr_d     = wr_addr;
            cmd_d      = 1'b0;
            last_rd_d  = 1'b0;
        end

        // Calibration loss abandons the burst silently.
        if (!init_calib && (state_q != IDLE)) begin
            state_d    = IDLE;
            cmd_en_d   = 1'b0;
            wr_grant_d = 1'b0;
            rd_grant_d = 1'b0;
            wr_rden_d  = 1'b0;
            wr_done_d  = 1'b0;
            to_done_d  = 1'b0;
            err_d      = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            timer_q    <= '0;
            gap_q      <= '0;
            addr_q     <= '0;
            cmd_q      <= 1'b0;
            cmd_en_q   <= 1'b0;
            last_rd_q  <= 1'b0;
            err_q      <= 1'b0;
            wr_grant_q <= 1'b0;
            rd_grant_q <= 1'b0;
            wr_rden_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            to_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            timer_q    <= timer_d;
            gap_q      <= gap_d;
            addr_q     <= addr_d;
            cmd_q      <= cmd_d;
            cmd_en_q   <= cmd_en_d;
            last_rd_q  <= last_rd_d;
            err_q      <= err_d;
            wr_grant_q <= wr_grant_d;
            rd_grant_q <= rd_grant_d;
            wr_rden_q  <= wr_rden_d;
            wr_done_q  <= wr_done_d;
            to_done_q  <= to_done_d;
        end
    end

    assign wr_grant       = wr_grant_q;
    assign rd_grant       = rd_grant_q;
    assign wr_rden        = wr_rden_q;
    assign wr_done        = wr_done_q;
    assign cmd            = cmd_q;
    assign cmd_en         = cmd_en_q;
    assign addr           = addr_q;
    assign rd_timeout_err = err_q;
    assign wr_data        = (state_q == WR_BURST) ? wr_data_in : '0;
    assign rd_data_out    = rd_data;
    assign rd_wren        = rd_active && rd_data_valid;
    assign rd_done        = to_done_q || rd_last;
    assign data_mask      = 4'h0;

endmodule

// File: tb/tb_hpram_arbiter.sv
// Directed bench for hpram_arbiter: reset/calibration gating, write and read
// bursts, round-robin alternation, read timeout and calibration abort.
module tb_hpram_arbiter;

    logic        clk = 1'b0;
    logic        rst, init_calib, wr_req, rd_req, rd_data_valid, fifo_clr;
    logic [21:0] wr_addr, rd_addr, addr;
    logic [31:0] wr_data_in, rd_data, rd_data_out, wr_data;
    logic [31:0] fifo_ptr;
    logic        wr_grant, wr_rden, wr_done, rd_grant, rd_wren, rd_done;
    logic        rd_timeout_err, cmd, cmd_en;
    logic [3:0]  data_mask;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    hpram_arbiter #(.BURST_WORDS(16), .CMD_GAP(4), .RD_TIMEOUT(256)) dut (
        .clk(clk), .rst(rst), .init_calib(init_calib),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_grant(wr_grant),
        .wr_rden(wr_rden), .wr_data_in(wr_data_in), .wr_done(wr_done),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_grant(rd_grant),
        .rd_data_out(rd_data_out), .rd_wren(rd_wren), .rd_done(rd_done),
        .rd_timeout_err(rd_timeout_err), .cmd(cmd), .cmd_en(cmd_en),
        .addr(addr), .wr_data(wr_data), .data_mask(data_mask),
        .rd_data_valid(rd_data_valid), .rd_data(rd_data)
    );

    // Write FIFO model with one-cycle read latency, counting data.
    always @(posedge clk) begin
        if (fifo_clr) fifo_ptr <= '0;
        else if (wr_rden) begin
            wr_data_in <= fifo_ptr;
            fifo_ptr   <= fifo_ptr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_grant(output bit got);
        got = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            #1;
            if (wr_grant || rd_grant) begin
                got = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int hits;
        bit got;
        rst = 1; init_calib = 0; wr_req = 1; rd_req = 1;
        wr_addr = 22'h0AAAAA; rd_addr = 22'h155555;
        rd_data_valid = 0; rd_data = '0; fifo_clr = 1;
        repeat (3) tick();
        rst = 0; fifo_clr = 0;
        #1;
        n_chk++;
        if ({wr_grant, rd_grant, cmd_en, cmd, wr_rden, wr_done,
             rd_done, rd_timeout_err, rd_wren} !== 9'b0 ||
            addr !== 22'h0 || data_mask !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_values: strobes %b addr %h mask %h required all zero",
                {wr_grant, rd_grant, cmd_en, cmd, wr_rden, wr_done,
                 rd_done, rd_timeout_err, rd_wren}, addr, data_mask);
        end
        hits = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            #1;
            if (wr_grant || rd_grant || cmd_en) hits++;
        end
        n_chk++;
        if (hits !== 0) begin
            n_fail++;
            $display("FAIL calib_block: %0d grant/cmd cycles, required 0", hits);
        end
        init_calib = 1;
        wait_grant(got);
        n_chk++;
        if (!got || rd_grant !== 1'b1 || wr_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL first_tie: got=%0d rd_grant=%b wr_grant=%b required read", got, rd_grant, wr_grant);
        end
        wr_req = 0; rd_req = 0;
        tick();
        #1;
        n_chk++;
        if (cmd_en !== 1'b1 || cmd !== 1'b1 || addr !== 22'h155555) begin
            n_fail++;
            $display("FAIL first_rd_cmd: cmd_en=%b cmd=%b addr=%h required 1 1 155555", cmd_en, cmd, addr);
        end
        for (int i = 0; i < 16; i++) begin
            tick();
            rd_data_valid = 1;
            rd_data = i;
        end
        tick();
        rd_data_valid = 0;
        repeat (8) tick();
    endtask

    task automatic test_single_write();
        bit got;
        int rden_cnt, data_err, done_at, next_cmd;
        fifo_clr = 1;
        tick();
        fifo_clr = 0;
        wr_addr = 22'h000100;
        wr_req = 1;
        wait_grant(got);
        n_chk++;
        if (!got || wr_grant !== 1'b1 || wr_rden !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_grant: got=%0d wr_grant=%b wr_rden=%b required 1 1", got, wr_grant, wr_rden);
        end
        rden_cnt = 1; data_err = 0; done_at = -1; next_cmd = -1;
        for (int k = 1; k <= 24; k++) begin
            tick();
            #1;
            if (k == 1) begin
                n_chk++;
                if (cmd_en !== 1'b1 || cmd !== 1'b0 || addr !== 22'h000100) begin
                    n_fail++;
                    $display("FAIL wr_cmd: cmd_en=%b cmd=%b addr=%h required 1 0 000100", cmd_en, cmd, addr);
                end
            end
            if (k <= 20 && wr_rden) rden_cnt++;
            if (k <= 16 && wr_data !== 32'(k - 1)) data_err++;
            if (wr_done && done_at < 0) done_at = k;
            if (k > 1 && cmd_en && next_cmd < 0) next_cmd = k;
            if (k > 1 && wr_grant) wr_req = 0;
        end
        n_chk++;
        if (rden_cnt !== 16) begin
            n_fail++;
            $display("FAIL wr_rden_len: %0d cycles, required 16", rden_cnt);
        end
        n_chk++;
        if (data_err !== 0) begin
            n_fail++;
            $display("FAIL wr_data_seq: %0d wrong words, required 0", data_err);
        end
        n_chk++;
        if (done_at !== 16) begin
            n_fail++;
            $display("FAIL wr_done_at: T+%0d, required T+16", done_at);
        end
        n_chk++;
        if (next_cmd < 21) begin
            n_fail++;
            $display("FAIL wr_cmd_gap: next cmd_en at T+%0d, required >= T+21", next_cmd);
        end
        wr_req = 0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            #1;
            if (wr_done) begin
                got = 1;
                break;
            end
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL wr_second_done: no wr_done within 40 cycles");
        end
        repeat (6) tick();
    endtask

    task automatic test_read_gapped();
        bit got, v;
        int sent, wren_err, data_err, done_cnt, done_at;
        rd_addr = 22'h2A5A5A;
        rd_req = 1;
        wait_grant(got);
        rd_req = 0;
        tick();
        #1;
        n_chk++;
        if (!got || cmd_en !== 1'b1 || cmd !== 1'b1 || addr !== 22'h2A5A5A) begin
            n_fail++;
            $display("FAIL rd_cmd: got=%0d cmd_en=%b cmd=%b addr=%h required 1 1 2a5a5a", got, cmd_en, cmd, addr);
        end
        sent = 0; wren_err = 0; data_err = 0; done_cnt = 0; done_at = -1;
        for (int k = 2; k <= 40; k++) begin
            tick();
            v = (k % 2 == 0) && (sent < 16);
            rd_data_valid = v;
            rd_data = v ? 32'hC0DE0000 + 32'(sent) : 32'hDEADBEEF;
            #1;
            if (rd_wren !== v) wren_err++;
            if (rd_wren && rd_data_out !== 32'hC0DE0000 + 32'(sent)) data_err++;
            if (rd_done) begin
                done_cnt++;
                done_at = v ? sent + 1 : 0;
            end
            if (v) sent++;
        end
        rd_data_valid = 0;
        n_chk++;
        if (wren_err !== 0) begin
            n_fail++;
            $display("FAIL rd_wren_pattern: %0d wrong cycles, required 0", wren_err);
        end
        n_chk++;
        if (data_err !== 0) begin
            n_fail++;
            $display("FAIL rd_data_pass: %0d wrong words, required 0", data_err);
        end
        n_chk++;
        if (done_cnt !== 1 || done_at !== 16) begin
            n_fail++;
            $display("FAIL rd_done_at: count %0d on word %0d, required 1 on word 16", done_cnt, done_at);
        end
        n_chk++;
        if (rd_timeout_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_no_timeout: rd_timeout_err=%b required 0", rd_timeout_err);
        end
    endtask

    task automatic test_round_robin();
        int pend, ngr, ncmd, last_cmd, min_sp, addr_err;
        logic [5:0] got_rd;
        rst = 1;
        rd_data_valid = 0;
        repeat (2) tick();
        rst = 0;
        wr_addr = 22'h011111; rd_addr = 22'h022222;
        wr_req = 1; rd_req = 1;
        pend = 0; ngr = 0; ncmd = 0; last_cmd = -100; min_sp = 1000;
        addr_err = 0; got_rd = '0;
        for (int k = 0; k < 500; k++) begin
            tick();
            rd_data_valid = (pend > 0);
            rd_data = k;
            if (pend > 0) pend--;
            #1;
            if ((rd_grant || wr_grant) && ngr < 6) begin
                got_rd[ngr] = rd_grant;
                ngr++;
                if (ngr == 6) begin
                    wr_req = 0;
                    rd_req = 0;
                end
            end
            if (cmd_en) begin
                if (ncmd > 0 && k - last_cmd < min_sp) min_sp = k - last_cmd;
                last_cmd = k;
                ncmd++;
                if (addr !== (cmd ? 22'h022222 : 22'h011111)) addr_err++;
                if (cmd) pend = 16;
            end
            if (ngr == 6 && ncmd == 6 && k - last_cmd > 40) break;
        end
        rd_data_valid = 0;
        n_chk++;
        if (ngr !== 6 || got_rd !== 6'b010101) begin
            n_fail++;
            $display("FAIL rr_order: %0d grants, read bits %b, required 6 and 010101", ngr, got_rd);
        end
        n_chk++;
        if (ncmd !== 6 || min_sp < 20) begin
            n_fail++;
            $display("FAIL rr_spacing: %0d cmds, min spacing %0d, required 6 and >= 20", ncmd, min_sp);
        end
        n_chk++;
        if (addr_err !== 0) begin
            n_fail++;
            $display("FAIL rr_addr: %0d wrong addresses, required 0", addr_err);
        end
    endtask

    task automatic test_timeout();
        bit got, v;
        int pre_err, pre_done, post_done, stray, wren_cnt;
        logic err_at, done_at;
        rd_addr = 22'h3C0000;
        rd_req = 1;
        wait_grant(got);
        rd_req = 0;
        tick();
        #1;
        n_chk++;
        if (!got || cmd_en !== 1'b1 || cmd !== 1'b1) begin
            n_fail++;
            $display("FAIL to_cmd: got=%0d cmd_en=%b cmd=%b required 1 1", got, cmd_en, cmd);
        end
        pre_err = 0; pre_done = 0; post_done = 0; stray = 0; wren_cnt = 0;
        err_at = 0; done_at = 0;
        for (int k = 2; k <= 270; k++) begin
            tick();
            v = (k <= 11) || (k >= 259 && k <= 264);
            rd_data_valid = v;
            rd_data = k;
            #1;
            if (k < 257 && rd_timeout_err) pre_err++;
            if (k < 257 && rd_done) pre_done++;
            if (k > 257 && rd_done) post_done++;
            if (k == 257) begin
                err_at = rd_timeout_err;
                done_at = rd_done;
            end
            if (k >= 259 && rd_wren) stray++;
            if (k <= 11 && rd_wren) wren_cnt++;
        end
        rd_data_valid = 0;
        n_chk++;
        if (wren_cnt !== 10) begin
            n_fail++;
            $display("FAIL to_words: %0d rd_wren, required 10", wren_cnt);
        end
        n_chk++;
        if (pre_err !== 0 || pre_done !== 0) begin
            n_fail++;
            $display("FAIL to_early: err cycles %0d done cycles %0d, required 0 0", pre_err, pre_done);
        end
        n_chk++;
        if (err_at !== 1'b1 || done_at !== 1'b1) begin
            n_fail++;
            $display("FAIL to_fire: err=%b done=%b at cmd+256, required 1 1", err_at, done_at);
        end
        n_chk++;
        if (post_done !== 0 || stray !== 0 || rd_timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL to_after: done %0d stray %0d err %b, required 0 0 1", post_done, stray, rd_timeout_err);
        end
        repeat (6) tick();
    endtask

    task automatic test_calib_abort();
        bit got;
        int bad;
        wr_addr = 22'h000040;
        wr_req = 1;
        wait_grant(got);
        wr_req = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 6) init_calib = 0;
            #1;
        end
        n_chk++;
        if (!got || wr_rden !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_midburst: got=%0d wr_rden=%b required 1 1", got, wr_rden);
        end
        tick();
        #1;
        n_chk++;
        if (wr_rden !== 1'b0 || wr_done !== 1'b0) begin
            n_fail++;
            $display("FAIL ab_stop: wr_rden=%b wr_done=%b required 0 0", wr_rden, wr_done);
        end
        bad = 0;
        for (int k = 8; k <= 30; k++) begin
            tick();
            #1;
            if (wr_done || cmd_en || wr_grant || rd_grant || wr_rden) bad++;
        end
        n_chk++;
        if (bad !== 0 || rd_timeout_err !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_idle: %0d active cycles err=%b, required 0 and 1", bad, rd_timeout_err);
        end
        init_calib = 1;
        wr_addr = 22'h3FFFFF;
        wr_req = 1;
        wait_grant(got);
        wr_req = 0;
        n_chk++;
        if (!got || wr_grant !== 1'b1) begin
            n_fail++;
            $display("FAIL ab_resume: got=%0d wr_grant=%b required 1 1", got, wr_grant);
        end
        tick();
        #1;
        n_chk++;
        if (cmd_en !== 1'b1 || cmd !== 1'b0 || addr !== 22'h3FFFFF) begin
            n_fail++;
            $display("FAIL ab_cmd: cmd_en=%b cmd=%b addr=%h required 1 0 3fffff", cmd_en, cmd, addr);
        end
        got = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            #1;
            if (wr_done) begin
                got = 1;
                break;
            end
        end
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL ab_done: no wr_done within 30 cycles after resume");
        end
        repeat (6) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_write();
        test_read_gapped();
        test_round_robin();
        test_timeout();
        test_calib_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
